// File: rtl/mio_bus_ctrl.sv
// Memory/IO bus controller between the multicycle core and data RAM + peripheral registers.
// Latency: accept-to-ready 1 cycle for writes/peripherals, RAM_LAT+1 cycles for RAM reads.
// Backpressure: 4-phase level handshake; mio_ready holds until cpu_mio drops, no re-execution.
module mio_bus_ctrl #(
  parameter int RAM_AW  = 10,
  parameter int RAM_LAT = 1,
  parameter int IO_W    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_mio,
  input  logic              mem_w,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              mio_ready,
  output logic [RAM_AW-1:0] ram_addr,
  output logic              ram_we,
  output logic [31:0]       ram_din,
  input  logic [31:0]       ram_dout,
  input  logic [IO_W-1:0]   sw_i,
  output logic [IO_W-1:0]   led_o,
  output logic [31:0]       seg_o,
  output logic              int_o
);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] RAM_WAIT = 2'd1;
  localparam logic [1:0] DONE     = 2'd2;
  localparam logic [2:0] LAT_INIT = 3'(RAM_LAT);

  logic [1:0]  state;
  logic [2:0]  wait_cnt;
  logic [31:0] counter;
  logic        accept;
  logic        sel_ram, sel_seg, sel_io, sel_ctr;
  logic        ctr_wr, ctr_rd, wrap;
  logic [31:0] per_rdata;
  logic        unused_addr_lsb;

  // Byte-lane bits are irrelevant: the bus is word-only.
  assign unused_addr_lsb = ^addr[1:0];

  // Address decode and accept qualification (request is only looked at in IDLE).
  always_comb begin
    accept  = (state == IDLE) && cpu_mio;
    sel_ram = (addr[31:28] == 4'h0);
    sel_seg = (addr[31:2] == 30'h3800_0000);
    sel_io  = (addr[31:2] == 30'h3C00_0000);
    sel_ctr = (addr[31:2] == 30'h3C00_0001);
    ctr_wr  = accept && mem_w && sel_ctr;
    ctr_rd  = accept && !mem_w && sel_ctr;
    // A counter load on the wrap cycle replaces the wrap, so no interrupt.
    wrap    = (counter == 32'hFFFF_FFFF) && !ctr_wr;
  end

  // Peripheral read mux; unmapped non-RAM addresses read as zero.
  always_comb begin
    per_rdata = 32'h0;
    if (sel_seg)      per_rdata = seg_o;
    else if (sel_io)  per_rdata = 32'(sw_i);
    else if (sel_ctr) per_rdata = counter;
  end

  // Handshake FSM: performs the access on the accept edge, or waits out RAM read latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      wait_cnt  <= 3'd0;
      rdata     <= 32'h0;
      mio_ready <= 1'b0;
      ram_addr  <= '0;
      ram_we    <= 1'b0;
      ram_din   <= 32'h0;
    end else begin
      ram_we <= 1'b0;
      case (state)
        IDLE: begin
          if (cpu_mio) begin
            if (sel_ram) ram_addr <= addr[RAM_AW+1:2];
            if (sel_ram && !mem_w) begin
              state    <= RAM_WAIT;
              wait_cnt <= LAT_INIT;
            end else begin
              if (sel_ram) begin
                ram_we  <= 1'b1;
                ram_din <= wdata;
              end
              if (!mem_w) rdata <= per_rdata;
              state     <= DONE;
              mio_ready <= 1'b1;
            end
          end
        end
        RAM_WAIT: begin
          // Count reaching zero on this edge means ram_dout is valid now.
          if (wait_cnt <= 3'd1) begin
            rdata     <= ram_dout;
            state     <= DONE;
            mio_ready <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt - 3'd1;
          end
        end
        DONE: begin
          if (!cpu_mio) begin
            state     <= IDLE;
            mio_ready <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          mio_ready <= 1'b0;
        end
      endcase
    end
  end

  // Peripheral registers: LED, seg7, free-running counter and its sticky wrap flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led_o   <= '0;
      seg_o   <= 32'h0;
      counter <= 32'h0;
      int_o   <= 1'b0;
    end else begin
      if (accept && mem_w && sel_seg) seg_o <= wdata;
      if (accept && mem_w && sel_io)  led_o <= wdata[IO_W-1:0];
      counter <= ctr_wr ? wdata : counter + 32'd1;
      // Wrap beats a same-cycle read-clear.
      if (wrap)        int_o <= 1'b1;
      else if (ctr_rd) int_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mio_bus_ctrl.sv
// Bench for mio_bus_ctrl: directed scenarios plus randomized transactions.
// A transaction-level reference model predicts register state, read data and latency.
// Requests are issued through a 4-phase handshake task with bounded waits.
module tb_mio_bus_ctrl;
  localparam int LAT = 3;
  localparam logic [2:0] R_RAM = 3'd0, R_SEG = 3'd1, R_IO = 3'd2, R_CTR = 3'd3, R_NONE = 3'd4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cpu_mio = 1'b0;
  logic        mem_w = 1'b0;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic [31:0] rdata;
  logic        mio_ready;
  logic [9:0]  ram_addr;
  logic        ram_we;
  logic [31:0] ram_din;
  logic [31:0] ram_dout;
  logic [15:0] sw_i = 16'h0;
  logic [15:0] led_o;
  logic [31:0] seg_o;
  logic        int_o;

  int n_checks = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mio_bus_ctrl #(.RAM_AW(10), .RAM_LAT(LAT), .IO_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .cpu_mio(cpu_mio), .mem_w(mem_w), .addr(addr),
    .wdata(wdata), .rdata(rdata), .mio_ready(mio_ready), .ram_addr(ram_addr),
    .ram_we(ram_we), .ram_din(ram_din), .ram_dout(ram_dout), .sw_i(sw_i),
    .led_o(led_o), .seg_o(seg_o), .int_o(int_o)
  );

  // RAM whose output reflects an address held stable for LAT cycles.
  logic [31:0] ram_mem [1024];
  logic [9:0]  a1 = 10'h0, a2 = 10'h0;
  always @(posedge clk) begin
    if (ram_we) ram_mem[ram_addr] <= ram_din;
    a1 <= ram_addr;
    a2 <= a1;
  end
  assign ram_dout = ram_mem[a2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [2:0] region(input logic [31:0] a);
    logic [31:0] w;
    w = {a[31:2], 2'b00};
    if (w[31:28] == 4'h0)    return R_RAM;
    if (w == 32'hE000_0000)  return R_SEG;
    if (w == 32'hF000_0000)  return R_IO;
    if (w == 32'hF000_0004)  return R_CTR;
    return R_NONE;
  endfunction

  // Reference model: architectural state updated at each accept edge, counter every cycle.
  logic        acc_now = 1'b0;
  logic [2:0]  kind;
  logic        c_wr, c_rd;
  logic [31:0] m_mem [1024];
  logic [31:0] m_ctr, m_seg, exp_rdata, exp_din;
  logic [15:0] m_led;
  logic        m_int, exp_we;
  logic [9:0]  exp_waddr;
  int          exp_lat = 1;
  int          cyc = 0;

  assign kind = region(addr);
  assign c_wr = acc_now && mem_w && (kind == R_CTR);
  assign c_rd = acc_now && !mem_w && (kind == R_CTR);

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ctr <= 32'h0; m_int <= 1'b0; m_led <= 16'h0; m_seg <= 32'h0;
      exp_we <= 1'b0; exp_waddr <= 10'h0; exp_din <= 32'h0;
    end else begin
      exp_we <= 1'b0;
      m_ctr  <= c_wr ? wdata : m_ctr + 32'd1;
      if (m_ctr == 32'hFFFF_FFFF && !c_wr) m_int <= 1'b1;
      else if (c_rd)                       m_int <= 1'b0;
      if (acc_now) begin
        exp_lat <= (kind == R_RAM && !mem_w) ? LAT + 1 : 1;
        case (kind)
          R_RAM: if (mem_w) begin
                   m_mem[addr[11:2]] <= wdata;
                   exp_we <= 1'b1; exp_waddr <= addr[11:2]; exp_din <= wdata;
                 end else exp_rdata <= m_mem[addr[11:2]];
          R_SEG: if (mem_w) m_seg <= wdata; else exp_rdata <= m_seg;
          R_IO:  if (mem_w) m_led <= wdata[15:0]; else exp_rdata <= {16'h0, sw_i};
          R_CTR: if (!mem_w) exp_rdata <= m_ctr;
          default: if (!mem_w) exp_rdata <= 32'h0;
        endcase
      end
    end
  end

  // Per-cycle comparison of register outputs and RAM write port.
  logic mon_en = 1'b0;
  int we_cnt = 0;
  logic [9:0]  last_waddr = 10'h0;
  logic [31:0] last_wdin = 32'h0;
  always @(negedge clk) begin
    if (rst_n && mon_en) begin
      chk("led_o", 32'(led_o), 32'(m_led));
      chk("seg_o", seg_o, m_seg);
      chk("int_o", 32'(int_o), 32'(m_int));
      chk("ram_we", 32'(ram_we), 32'(exp_we));
      if (exp_we) begin
        chk("ram_addr", 32'(ram_addr), 32'(exp_waddr));
        chk("ram_din", ram_din, exp_din);
      end
      if (ram_we) begin
        we_cnt     <= we_cnt + 1;
        last_waddr <= ram_addr;
        last_wdin  <= ram_din;
      end
    end
  end

  task automatic access(input logic we, input logic [31:0] a, input logic [31:0] d,
                        input int hold, output int lat, output logic [31:0] rd, output int acyc);
    @(negedge clk);
    cpu_mio = 1'b1; mem_w = we; addr = a; wdata = d; acc_now = 1'b1;
    @(negedge clk);
    acc_now = 1'b0;
    acyc = cyc;
    // Request fields are ignored after accept; disturb them.
    mem_w = 1'($urandom); addr = $urandom; wdata = $urandom;
    lat = 1;
    while (!mio_ready && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("latency", 32'(lat), 32'(exp_lat));
    rd = rdata;
    if (!we) chk("rdata", rd, exp_rdata);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("ready_hold", 32'(mio_ready), 32'd1);
      chk("rdata_hold", rdata, rd);
    end
    cpu_mio = 1'b0;
    @(negedge clk);
    chk("ready_drop", 32'(mio_ready), 32'd0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_rdata"}, rdata, 32'h0);
    chk({tag, "_ready"}, 32'(mio_ready), 32'd0);
    chk({tag, "_ram_we"}, 32'(ram_we), 32'd0);
    chk({tag, "_ram_addr"}, 32'(ram_addr), 32'd0);
    chk({tag, "_ram_din"}, ram_din, 32'h0);
    chk({tag, "_led"}, 32'(led_o), 32'd0);
    chk({tag, "_seg"}, seg_o, 32'h0);
    chk({tag, "_int"}, 32'(int_o), 32'd0);
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog: simulation did not finish in time");
    $display("Result: errors=%0d of %0d checks", n_err + 1, n_checks + 1);
    $fatal(1);
  end

  int lat, acyc, w0, n, r;
  logic [31:0] rd, a, d, seg_before;
  logic we;

  initial begin
    for (int i = 0; i < 1024; i++) begin
      ram_mem[i] = 32'h0;
      m_mem[i]   = 32'h0;
    end
    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    rst_n = 1'b1;
    mon_en = 1'b1;

    // 1: RAM write
    w0 = we_cnt;
    access(1'b1, 32'h0000_0010, 32'h1234_5678, 0, lat, rd, acyc);
    chk("t1_lat", 32'(lat), 32'd1);
    chk("t1_we_pulses", 32'(we_cnt - w0), 32'd1);
    chk("t1_ram_addr", 32'(last_waddr), 32'd4);
    chk("t1_ram_din", last_wdin, 32'h1234_5678);

    // 2: RAM read with hold
    access(1'b0, 32'h0000_0010, 32'h0, 5, lat, rd, acyc);
    chk("t2_lat", 32'(lat), 32'd4);
    chk("t2_rdata", rd, 32'h1234_5678);

    // 3: LEDs and switches
    access(1'b1, 32'hF000_0000, 32'hFFFF_A5A5, 1, lat, rd, acyc);
    chk("t3_led", 32'(led_o), 32'h0000_A5A5);
    sw_i = 16'h00FF;
    access(1'b0, 32'hF000_0000, 32'h0, 0, lat, rd, acyc);
    chk("t3_sw", rd, 32'h0000_00FF);

    // 4: counter wrap interrupt
    access(1'b1, 32'hF000_0004, 32'hFFFF_FFFD, 0, lat, rd, acyc);
    n = 0;
    while (!int_o && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("t4_int_delay", 32'(cyc - acyc), 32'd3);
    access(1'b0, 32'hF000_0004, 32'h0, 0, lat, rd, acyc);
    chk("t4_ctr_small", 32'(rd < 32'd32), 32'd1);
    chk("t4_int_clear", 32'(int_o), 32'd0);

    // 5: unmapped
    access(1'b0, 32'h8000_0000, 32'h0, 0, lat, rd, acyc);
    chk("t5_lat", 32'(lat), 32'd1);
    chk("t5_rdata", rd, 32'h0);
    w0 = we_cnt;
    seg_before = seg_o;
    access(1'b1, 32'h8000_0000, 32'hDEAD_BEEF, 0, lat, rd, acyc);
    chk("t5_no_we", 32'(we_cnt - w0), 32'd0);
    chk("t5_led", 32'(led_o), 32'h0000_A5A5);
    chk("t5_seg", seg_o, seg_before);

    // 6: reset in the middle of a RAM read
    @(negedge clk);
    cpu_mio = 1'b1; mem_w = 1'b0; addr = 32'h0000_0010; acc_now = 1'b1;
    @(negedge clk);
    acc_now = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("abort");
    cpu_mio = 1'b0;
    repeat (2) @(negedge clk);
    chk("abort_ready_low", 32'(mio_ready), 32'd0);
    rst_n = 1'b1;
    access(1'b0, 32'h0000_0010, 32'h0, 5, lat, rd, acyc);
    chk("t6_lat", 32'(lat), 32'd4);
    chk("t6_rdata", rd, 32'h1234_5678);

    // Randomized traffic
    for (int t = 0; t < 80; t++) begin
      r  = $urandom_range(0, 5);
      we = 1'($urandom);
      d  = $urandom;
      case (r)
        0: a = (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
        1: a = {4'h0, 28'($urandom)};
        2: a = 32'hE000_0000 | 32'($urandom_range(0, 3));
        3: a = 32'hF000_0000 | 32'($urandom_range(0, 3));
        4: begin
             a = 32'hF000_0004 | 32'($urandom_range(0, 3));
             if (we && $urandom_range(0, 1) == 1) d = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
           end
        default: a = ($urandom_range(0, 3) == 0) ? 32'hF000_0008
                                                : {4'($urandom_range(1, 13)), 28'($urandom)};
      endcase
      sw_i = 16'($urandom);
      access(we, a, d, $urandom_range(0, 3), lat, rd, acyc);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
